// File: rtl/io_disp_pkg.sv
// Shared types and constants for the io0 seven-segment display peripheral.
// Segment codes are active-low, bit order {g,f,e,d,c,b,a}.
package io_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Index 0 is the rightmost element: the list runs F down to 0.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // ceil(data_w * log10(2)): decimal digits needed for a data_w-bit unsigned value.
  function automatic int bcd_digits(input int data_w);
    return (data_w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/hex_seg7.sv
// Combinational 4-bit value to active-low seven-segment encoder.
module hex_seg7
  import io_disp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg_n
);

  assign seg_n = SEG_TABLE[digit];

endmodule

// File: rtl/io_hex_display.sv
// Captures CPU io0 writes and drives NUM_DIGITS seven-segment digits in hex
// or unsigned decimal (sequential double-dabble), with a one-deep pending slot.
module io_hex_display
  import io_disp_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NUM_DIGITS = 8,
  parameter int BLANK_LZ   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W-1:0]           io_data,
  input  logic                        io_we,
  input  logic                        dec_en,
  output logic                        busy,
  output logic                        ovf,
  output logic [NUM_DIGITS-1:0][6:0]  hex_n
);

  localparam int BCD_N = bcd_digits(DATA_W);
  localparam int EXT_N = (BCD_N > NUM_DIGITS) ? BCD_N : NUM_DIGITS;
  localparam int HEX_W = (DATA_W > NUM_DIGITS * 4) ? DATA_W : NUM_DIGITS * 4;
  localparam int CNT_W = $clog2(DATA_W + 1);

  state_t                      state_q;
  logic [DATA_W-1:0]           bin_q;
  logic [BCD_N*4-1:0]          bcd_q;
  logic [CNT_W-1:0]            cnt_q;
  logic                        dec_q;

  logic                        pend_vld_q;
  logic [DATA_W-1:0]           pend_data_q;
  logic                        pend_dec_q;

  logic [NUM_DIGITS-1:0][3:0]  digit_q;
  logic [NUM_DIGITS-1:0]       blank_q;
  logic [NUM_DIGITS-1:0]       dash_q;
  logic                        ovf_q;

  logic [BCD_N*4-1:0]          bcd_adj;
  logic [EXT_N*4-1:0]          dec_ext;
  logic [HEX_W-1:0]            hex_ext;
  logic [NUM_DIGITS-1:0][3:0]  res_digit;
  logic [NUM_DIGITS-1:0]       res_blank;
  logic [NUM_DIGITS-1:0]       res_dash;
  logic                        res_ovf;
  logic                        seen_nz;

  assign busy = (state_q != IDLE) || pend_vld_q;
  assign ovf  = ovf_q;

  // Double-dabble correction: add 3 to every BCD nibble >= 5 before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_N; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
    end
  end

  // Display image derived from the finished conversion (or raw value in hex mode).
  always_comb begin
    dec_ext                = '0;
    dec_ext[BCD_N*4-1:0]   = bcd_q;
    hex_ext                = '0;
    hex_ext[DATA_W-1:0]    = bin_q;
    res_ovf                = 1'b0;
    seen_nz                = 1'b0;
    res_digit              = '0;
    res_blank              = '0;
    res_dash               = '0;

    for (int i = NUM_DIGITS; i < EXT_N; i++) begin
      if (dec_q && (dec_ext[i*4 +: 4] != 4'd0)) begin
        res_ovf = 1'b1;
      end
    end

    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      res_digit[i] = dec_q ? dec_ext[i*4 +: 4] : hex_ext[i*4 +: 4];
      if (dec_ext[i*4 +: 4] != 4'd0) begin
        seen_nz = 1'b1;
      end
      res_blank[i] = dec_q && (BLANK_LZ != 0) && !seen_nz && (i != 0);
      res_dash[i]  = res_ovf;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      dec_q       <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_data_q <= '0;
      pend_dec_q  <= 1'b0;
      digit_q     <= '0;
      blank_q     <= '1;
      dash_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      // Every write lands in the pending slot; the newest write always wins.
      if (io_we) begin
        pend_vld_q  <= 1'b1;
        pend_data_q <= io_data;
        pend_dec_q  <= dec_en;
      end else if (state_q == IDLE && pend_vld_q) begin
        pend_vld_q  <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (pend_vld_q) begin
            bin_q   <= pend_data_q;
            dec_q   <= pend_dec_q;
            bcd_q   <= '0;
            cnt_q   <= '0;
            state_q <= pend_dec_q ? SHIFT : DONE;
          end
        end
        SHIFT: begin
          bcd_q <= {bcd_adj[BCD_N*4-2:0], bin_q[DATA_W-1]};
          bin_q <= {bin_q[DATA_W-2:0], 1'b0};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          digit_q <= res_digit;
          blank_q <= res_blank;
          dash_q  <= res_dash;
          ovf_q   <= res_ovf;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    logic [6:0] seg;
    hex_seg7 u_seg (
      .digit (digit_q[g]),
      .seg_n (seg)
    );
    assign hex_n[g] = dash_q[g] ? SEG_DASH : (blank_q[g] ? SEG_BLANK : seg);
  end

endmodule

// File: tb/tb_io_hex_display.sv
// Scoreboard bench for io_hex_display: stimulus pushes expected display images
// with their expected update cycle; a monitor pops on every display change.
module tb_io_hex_display;

  logic            clk;
  logic            rst;
  logic [31:0]     io_data;
  logic            io_we;
  logic            dec_en;
  logic            busy;
  logic            ovf;
  logic [7:0][6:0] hex_n;

  io_hex_display #(.DATA_W(32), .NUM_DIGITS(8), .BLANK_LZ(1)) dut (
    .clk     (clk),
    .rst     (rst),
    .io_data (io_data),
    .io_we   (io_we),
    .dec_en  (dec_en),
    .busy    (busy),
    .ovf     (ovf),
    .hex_n   (hex_n)
  );

  typedef struct {
    logic [55:0] img;
    logic        ovf;
    int          cyc;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  bit          mon_en   = 0;
  bit          track_busy = 0;
  bit          busy_drop  = 0;
  logic [55:0] prev_img;
  logic        prev_ovf;

  localparam logic [55:0] BLANK_ALL  = {8{7'h7F}};
  localparam logic [55:0] E_DEADBEEF = {7'h21, 7'h06, 7'h08, 7'h21, 7'h03, 7'h06, 7'h06, 7'h0E};
  localparam logic [55:0] E_12345    = {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12};
  localparam logic [55:0] E_ZERO     = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
  localparam logic [55:0] E_DASH     = {8{7'h3F}};
  localparam logic [55:0] E_NINES    = {8{7'h10}};
  localparam logic [55:0] E_SEVEN    = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78};
  localparam logic [55:0] E_99       = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h10, 7'h10};
  localparam logic [55:0] E_FF_HEX   = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h0E, 7'h0E};
  localparam logic [55:0] E_255_DEC  = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h24, 7'h12, 7'h12};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (track_busy && !busy) busy_drop = 1'b1;
  end

  // Monitor: any change of the display is an output event to be matched.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && (hex_n !== prev_img || ovf !== prev_ovf)) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_update hex_n=%h ovf=%b required=no change", hex_n, ovf);
      end else begin
        e = sb.pop_front();
        checks++;
        if (hex_n !== e.img) begin
          failures++;
          $display("FAIL %s_img got=%h exp=%h", e.name, hex_n, e.img);
        end
        checks++;
        if (ovf !== e.ovf) begin
          failures++;
          $display("FAIL %s_ovf got=%b exp=%b", e.name, ovf, e.ovf);
        end
        checks++;
        if (cyc != e.cyc) begin
          failures++;
          $display("FAIL %s_latency got_cycle=%0d exp_cycle=%0d", e.name, cyc, e.cyc);
        end
      end
    end
    prev_img = hex_n;
    prev_ovf = ovf;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] d, input logic dec, output int n);
    @(negedge clk);
    io_data = d;
    dec_en  = dec;
    io_we   = 1'b1;
    @(posedge clk);
    #1;
    n     = cyc;
    io_we = 1'b0;
  endtask

  task automatic push(input logic [55:0] img, input logic o, input int c, input string name);
    exp_t e;
    e.img  = img;
    e.ovf  = o;
    e.cyc  = c;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic drain(input string name, input int limit);
    int k;
    k = 0;
    while (sb.size() != 0 && k < limit) begin
      @(posedge clk);
      k++;
    end
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout pending=%0d exp=0 after %0d cycles", name, sb.size(), limit);
      sb.delete();
    end
    check({name, "_busy_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int n, n7, n42, n99;
    rst     = 1'b1;
    io_data = '0;
    io_we   = 1'b0;
    dec_en  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hex", 64'(hex_n), 64'(BLANK_ALL));
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    // Hex mode, busy for exactly two cycles.
    do_write(32'hDEADBEEF, 1'b0, n);
    push(E_DEADBEEF, 1'b0, n + 2, "hex_deadbeef");
    check("hex_busy_n0", 64'(busy), 64'd1);
    @(posedge clk); #1;
    check("hex_busy_n1", 64'(busy), 64'd1);
    @(posedge clk); #1;
    check("hex_busy_n2", 64'(busy), 64'd0);
    drain("hex_deadbeef", 20);

    do_write(32'd12345, 1'b1, n);
    push(E_12345, 1'b0, n + 34, "dec_12345");
    drain("dec_12345", 60);

    do_write(32'd0, 1'b1, n);
    push(E_ZERO, 1'b0, n + 34, "dec_zero");
    drain("dec_zero", 60);

    do_write(32'd100000000, 1'b1, n);
    push(E_DASH, 1'b1, n + 34, "dec_ovf");
    drain("dec_ovf", 60);

    do_write(32'd99999999, 1'b1, n);
    push(E_NINES, 1'b0, n + 34, "dec_nines");
    drain("dec_nines", 60);

    // Back-to-back: 42 is overwritten by 99 in the pending slot.
    do_write(32'd7, 1'b1, n7);
    push(E_SEVEN, 1'b0, n7 + 34, "b2b_seven");
    track_busy = 1'b1;
    busy_drop  = 1'b0;
    repeat (4) @(posedge clk);
    do_write(32'd42, 1'b1, n42);
    repeat (3) @(posedge clk);
    do_write(32'd99, 1'b1, n99);
    push(E_99, 1'b0, n7 + 68, "b2b_99");
    while (cyc < n7 + 67) @(posedge clk);
    @(negedge clk);
    track_busy = 1'b0;
    check("b2b_busy_continuous", 64'(busy_drop), 64'd0);
    drain("b2b", 100);

    do_write(32'd255, 1'b0, n);
    push(E_FF_HEX, 1'b0, n + 2, "mode_hex_255");
    drain("mode_hex_255", 20);

    do_write(32'd255, 1'b1, n);
    push(E_255_DEC, 1'b0, n + 34, "mode_dec_255");
    drain("mode_dec_255", 60);

    // Reset in the middle of a conversion aborts it and blanks the display.
    mon_en = 1'b0;
    do_write(32'd1000, 1'b1, n);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_hex", 64'(hex_n), 64'(BLANK_ALL));
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    check("midrst_no_update", 64'(hex_n), 64'(BLANK_ALL));
    check("midrst_busy_after", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
